// File: rtl/hud_flash_ctrl.sv
// HUD flash controller: latches drum hits and picks one drum at a time,
// round-robin, to flash the overlay blob. Visible state changes only at
// frame_tick, so the blob never tears mid-frame.
module hud_flash_ctrl #(
  parameter int HOLD_FRAMES = 8,
  parameter int X_BASE      = 0,
  parameter int X_STEP      = 256,
  parameter int Y_POS       = 528
) (
  input  logic        pixel_clk,
  input  logic        reset,
  input  logic [3:0]  hit,
  input  logic        frame_tick,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        hud_en,
  output logic [1:0]  active_drum,
  output logic [3:0]  pending
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_FRAMES - 1);
  localparam logic [9:0] Y_VAL       = 10'(Y_POS);

  state_t     state;
  logic [7:0] cnt;
  logic [1:0] last_grant;

  logic       grant_valid;
  logic [1:0] grant_drum;
  logic [1:0] search_idx;
  logic       retrigger;
  logic [3:0] clear_mask;

  // Overlay x for a drum; wraps modulo 2048 like the raster counter does.
  function automatic logic [10:0] drum_x(input logic [1:0] d);
    int v;
    v = X_BASE + int'(d) * X_STEP;
    return 11'(v);
  endfunction

  // Round-robin search starting just after the last granted drum.
  always_comb begin
    grant_valid = 1'b0;
    grant_drum  = last_grant;
    search_idx  = last_grant;
    for (int i = 1; i <= 4; i++) begin
      search_idx = last_grant + 2'(i);
      if (!grant_valid && pending[search_idx]) begin
        grant_valid = 1'b1;
        grant_drum  = search_idx;
      end
    end
  end

  // Pending bits consumed this cycle by a grant or a retrigger.
  always_comb begin
    clear_mask = 4'b0000;
    retrigger  = (state == SHOW) && pending[active_drum];
    if (frame_tick) begin
      if (state == SHOW) begin
        if (retrigger) clear_mask[active_drum] = 1'b1;
      end else if (grant_valid) begin
        clear_mask[grant_drum] = 1'b1;
      end
    end
  end

  // Hit latching, frame-aligned FSM and registered overlay outputs.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 8'd0;
      last_grant  <= 2'd3;
      pending     <= 4'b0000;
      x           <= 11'd0;
      y           <= 10'd0;
      hud_en      <= 1'b0;
      active_drum <= 2'd0;
    end else begin
      // A new hit beats a same-cycle clear so no hit is ever lost.
      pending <= (pending & ~clear_mask) | hit;
      if (frame_tick) begin
        case (state)
          IDLE, GAP: begin
            if (grant_valid) begin
              state       <= SHOW;
              last_grant  <= grant_drum;
              active_drum <= grant_drum;
              x           <= drum_x(grant_drum);
              y           <= Y_VAL;
              hud_en      <= 1'b1;
              cnt         <= HOLD_RELOAD;
            end else begin
              state  <= IDLE;
              hud_en <= 1'b0;
            end
          end
          SHOW: begin
            if (retrigger) begin
              cnt <= HOLD_RELOAD;
            end else if (cnt == 8'd0) begin
              state  <= GAP;
              hud_en <= 1'b0;
            end else begin
              cnt <= cnt - 8'd1;
            end
          end
          default: begin
            state  <= IDLE;
            hud_en <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hud_flash_ctrl.sv
// Testbench for hud_flash_ctrl (HOLD_FRAMES=2): table of per-cycle vectors
// with expected outputs, scoreboarded through a queue, plus a hand-written
// reset-during-GAP sequence.
module tb_hud_flash_ctrl;

  localparam logic [9:0] YV = 10'd528;

  typedef struct {
    logic        rst;
    logic [3:0]  hit;
    logic        tick;
    logic        en;
    logic [1:0]  drum;
    logic [10:0] x;
    logic [9:0]  y;
    logic [3:0]  pend;
  } vec_t;

  logic        pixel_clk;
  logic        reset;
  logic [3:0]  hit;
  logic        frame_tick;
  logic [10:0] x;
  logic [9:0]  y;
  logic        hud_en;
  logic [1:0]  active_drum;
  logic [3:0]  pending;

  vec_t vecs[$];
  vec_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_no = 0;

  hud_flash_ctrl #(
    .HOLD_FRAMES(2)
  ) dut (
    .pixel_clk  (pixel_clk),
    .reset      (reset),
    .hit        (hit),
    .frame_tick (frame_tick),
    .x          (x),
    .y          (y),
    .hud_en     (hud_en),
    .active_drum(active_drum),
    .pending    (pending)
  );

  // Free-running pixel clock.
  initial begin
    pixel_clk = 1'b0;
    forever #5 pixel_clk = ~pixel_clk;
  end

  function automatic vec_t mk(input logic r, input logic [3:0] h, input logic t,
                              input logic e, input logic [1:0] d,
                              input logic [10:0] xx, input logic [9:0] yy,
                              input logic [3:0] p);
    vec_t v;
    v.rst = r; v.hit = h; v.tick = t;
    v.en = e; v.drum = d; v.x = xx; v.y = yy; v.pend = p;
    return v;
  endfunction

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL vec%0d %s: got %0d expected %0d", vec_no, name, act, req);
    end
  endtask

  // Pop the oldest expectation and compare it against the registered outputs.
  task automatic checkOutput();
    vec_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL vec%0d scoreboard: got empty queue expected entry", vec_no);
    end else begin
      e = exp_q.pop_front();
      cmp("hud_en", int'(hud_en), int'(e.en));
      cmp("active_drum", int'(active_drum), int'(e.drum));
      cmp("x", int'(x), int'(e.x));
      cmp("y", int'(y), int'(e.y));
      cmp("pending", int'(pending), int'(e.pend));
    end
  endtask

  // Drive one cycle of inputs, record its expectation, check after the edge.
  task automatic applyStimulus(input vec_t v);
    reset      = v.rst;
    hit        = v.hit;
    frame_tick = v.tick;
    exp_q.push_back(v);
    @(posedge pixel_clk);
    #1;
    checkOutput();
    vec_no++;
  endtask

  initial begin
    reset = 1'b1; hit = 4'b0; frame_tick = 1'b0;

    // Single hit on drum 2, shown two frames then blanked.
    vecs.push_back(mk(1, 4'h0, 0, 0, 0, 0,   0,  4'h0));
    vecs.push_back(mk(0, 4'h4, 0, 0, 0, 0,   0,  4'h4));
    vecs.push_back(mk(0, 4'h0, 1, 1, 2, 512, YV, 4'h0));
    vecs.push_back(mk(0, 4'h0, 0, 1, 2, 512, YV, 4'h0));
    vecs.push_back(mk(0, 4'h0, 1, 1, 2, 512, YV, 4'h0));
    vecs.push_back(mk(0, 4'h0, 1, 0, 2, 512, YV, 4'h0));
    vecs.push_back(mk(0, 4'h0, 1, 0, 2, 512, YV, 4'h0));
    // All four drums at once: served 0,1,2,3 with one blank frame between.
    vecs.push_back(mk(1, 4'h0, 0, 0, 0, 0,   0,  4'h0));
    vecs.push_back(mk(0, 4'hF, 0, 0, 0, 0,   0,  4'hF));
    vecs.push_back(mk(0, 4'h0, 1, 1, 0, 0,   YV, 4'hE));
    vecs.push_back(mk(0, 4'h0, 1, 1, 0, 0,   YV, 4'hE));
    vecs.push_back(mk(0, 4'h0, 1, 0, 0, 0,   YV, 4'hE));
    vecs.push_back(mk(0, 4'h0, 1, 1, 1, 256, YV, 4'hC));
    vecs.push_back(mk(0, 4'h0, 1, 1, 1, 256, YV, 4'hC));
    vecs.push_back(mk(0, 4'h0, 1, 0, 1, 256, YV, 4'hC));
    vecs.push_back(mk(0, 4'h0, 1, 1, 2, 512, YV, 4'h8));
    vecs.push_back(mk(0, 4'h0, 1, 1, 2, 512, YV, 4'h8));
    vecs.push_back(mk(0, 4'h0, 1, 0, 2, 512, YV, 4'h8));
    vecs.push_back(mk(0, 4'h0, 1, 1, 3, 768, YV, 4'h0));
    vecs.push_back(mk(0, 4'h0, 1, 1, 3, 768, YV, 4'h0));
    vecs.push_back(mk(0, 4'h0, 1, 0, 3, 768, YV, 4'h0));
    vecs.push_back(mk(0, 4'h0, 1, 0, 3, 768, YV, 4'h0));
    vecs.push_back(mk(0, 4'h0, 1, 0, 3, 768, YV, 4'h0));
    // Retrigger of drum 1 while showing reloads the hold counter.
    vecs.push_back(mk(1, 4'h0, 0, 0, 0, 0,   0,  4'h0));
    vecs.push_back(mk(0, 4'h2, 0, 0, 0, 0,   0,  4'h2));
    vecs.push_back(mk(0, 4'h0, 1, 1, 1, 256, YV, 4'h0));
    vecs.push_back(mk(0, 4'h2, 0, 1, 1, 256, YV, 4'h2));
    vecs.push_back(mk(0, 4'h0, 1, 1, 1, 256, YV, 4'h0));
    vecs.push_back(mk(0, 4'h0, 1, 1, 1, 256, YV, 4'h0));
    vecs.push_back(mk(0, 4'h0, 1, 0, 1, 256, YV, 4'h0));
    // Hit on drum 3 coinciding with its grant survives, then retriggers.
    vecs.push_back(mk(1, 4'h0, 0, 0, 0, 0,   0,  4'h0));
    vecs.push_back(mk(0, 4'h8, 0, 0, 0, 0,   0,  4'h8));
    vecs.push_back(mk(0, 4'h8, 1, 1, 3, 768, YV, 4'h8));
    vecs.push_back(mk(0, 4'h0, 1, 1, 3, 768, YV, 4'h0));
    vecs.push_back(mk(0, 4'h0, 1, 1, 3, 768, YV, 4'h0));
    vecs.push_back(mk(0, 4'h0, 1, 0, 3, 768, YV, 4'h0));
    // Reset in the middle of SHOW with other hits pending.
    vecs.push_back(mk(1, 4'h0, 0, 0, 0, 0,   0,  4'h0));
    vecs.push_back(mk(0, 4'h4, 0, 0, 0, 0,   0,  4'h4));
    vecs.push_back(mk(0, 4'h0, 1, 1, 2, 512, YV, 4'h0));
    vecs.push_back(mk(0, 4'hA, 0, 1, 2, 512, YV, 4'hA));
    vecs.push_back(mk(1, 4'h0, 0, 0, 0, 0,   0,  4'h0));
    vecs.push_back(mk(0, 4'h0, 1, 0, 0, 0,   0,  4'h0));
    vecs.push_back(mk(0, 4'h0, 1, 0, 0, 0,   0,  4'h0));
    // Mid-frame hits do not disturb outputs; round robin from last grant.
    vecs.push_back(mk(1, 4'h0, 0, 0, 0, 0,   0,  4'h0));
    vecs.push_back(mk(0, 4'h2, 0, 0, 0, 0,   0,  4'h2));
    vecs.push_back(mk(0, 4'h0, 1, 1, 1, 256, YV, 4'h0));
    vecs.push_back(mk(0, 4'h4, 0, 1, 1, 256, YV, 4'h4));
    vecs.push_back(mk(0, 4'h8, 0, 1, 1, 256, YV, 4'hC));
    vecs.push_back(mk(0, 4'h1, 0, 1, 1, 256, YV, 4'hD));
    vecs.push_back(mk(0, 4'h0, 1, 1, 1, 256, YV, 4'hD));
    vecs.push_back(mk(0, 4'h0, 1, 0, 1, 256, YV, 4'hD));
    vecs.push_back(mk(0, 4'h0, 1, 1, 2, 512, YV, 4'h9));
    vecs.push_back(mk(0, 4'h0, 1, 1, 2, 512, YV, 4'h9));
    vecs.push_back(mk(0, 4'h0, 1, 0, 2, 512, YV, 4'h9));
    vecs.push_back(mk(0, 4'h0, 1, 1, 3, 768, YV, 4'h1));
    vecs.push_back(mk(0, 4'h0, 1, 1, 3, 768, YV, 4'h1));
    vecs.push_back(mk(0, 4'h0, 1, 0, 3, 768, YV, 4'h1));
    vecs.push_back(mk(0, 4'h0, 1, 1, 0, 0,   YV, 4'h0));

    @(posedge pixel_clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
    end

    // Drum 0 is showing; run it into GAP, then reset with hit and tick
    // asserted, which must both be ignored. Priority restarts at drum 0.
    applyStimulus(mk(0, 4'h0, 1, 1, 0, 0, YV, 4'h0));
    applyStimulus(mk(0, 4'h0, 1, 0, 0, 0, YV, 4'h0));
    applyStimulus(mk(1, 4'hF, 1, 0, 0, 0, 0,  4'h0));
    applyStimulus(mk(0, 4'h0, 1, 0, 0, 0, 0,  4'h0));
    applyStimulus(mk(0, 4'h3, 0, 0, 0, 0, 0,  4'h3));
    applyStimulus(mk(0, 4'h0, 1, 1, 0, 0, YV, 4'h2));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
